c_core_reset_sequencer: RTL and testbench

Consumes the raw core-reset request bit driven from C by the testbench reset driver and turns it into a clean, clock-synchronous, sequenced reset pair for the DUT. A peripheral/bus reset is released first and the core reset follows a fixed gap later. A minimum assertion width is enforced, a completion pulse is emitted, and reset events are counted for the bench scoreboard. Sits in the testbench between the DPI reset driver and the DUT reset pins.

---
 rtl/c_core_reset_pkg.sv | 14 +
 rtl/c_core_reset_sync.sv | 25 ++
 rtl/c_core_reset_sequencer.sv | 157 +++++++++++++++
 tb/tb_c_core_reset_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/c_core_reset_pkg.sv
// Shared types and constants for the core reset sequencer.
package c_core_reset_pkg;

    // Sequencer states: both resets held, peripheral released, fully running.
    typedef enum logic [1:0] {
        StAssert    = 2'd0,
        StRelPeriph = 2'd1,
        StRun       = 2'd2
    } seq_state_e;

    localparam int unsigned ResetCountWidth = 16;
    localparam logic [ResetCountWidth-1:0] ResetCountSat = '1;

endpackage

// File: rtl/c_core_reset_sync.sv
// N-stage synchronizer for the raw reset request; all flops reset to 1 so a
// request is assumed while rst_ni is low.
module c_core_reset_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/c_core_reset_sequencer.sv
// Turns a raw asynchronous reset request into a sequenced reset pair:
// peripheral reset released first, core reset RELEASE_GAP cycles later.
// Enforces a minimum assertion width, pulses reset_done_o on core release and
// counts re-entries into reset.
// Optional: define C_CORE_RESET_SEQ_GLITCH_FILTER_EN to insert a stability
// filter of FILTER_CYCLES between the synchronizer and the FSM.
module c_core_reset_sequencer
    import c_core_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned MIN_ASSERT_CYCLES = 16,
    parameter int unsigned RELEASE_GAP       = 4,
    parameter int unsigned FILTER_CYCLES     = 4,
    parameter logic [ResetCountWidth-1:0] COUNT_SAT = ResetCountSat
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_i,
    output logic                       periph_reset_o,
    output logic                       core_reset_o,
    output logic                       reset_done_o,
    output logic [ResetCountWidth-1:0] reset_count_o
);

    localparam int unsigned CntMax = (MIN_ASSERT_CYCLES > RELEASE_GAP) ?
                                     MIN_ASSERT_CYCLES : RELEASE_GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] AssertLast = CntW'(MIN_ASSERT_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast    = CntW'(RELEASE_GAP - 1);

    logic req_s;
    logic req_fsm;

    c_core_reset_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (req_i),
        .q_o   (req_s)
    );

`ifdef C_CORE_RESET_SEQ_GLITCH_FILTER_EN
    localparam int unsigned FiltW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_CYCLES - 1);

    logic             filt_q, filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;

    // Accept a new request level only after it has been stable long enough.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (req_s != filt_q) begin
            if (filt_cnt_q == FiltLast) begin
                filt_d = req_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Filter state register; the filtered level starts as "requesting".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign req_fsm = filt_q;
`else
    logic unused_filter_cfg;
    assign unused_filter_cfg = ^FILTER_CYCLES;
    assign req_fsm = req_s;
`endif

    seq_state_e                 state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       periph_q, core_q, done_q, done_d;
    logic [ResetCountWidth-1:0] count_q, count_d;
    logic                       count_inc;

    // Next-state logic; the request check wins over gap expiry in StRelPeriph.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        count_inc = 1'b0;
        unique case (state_q)
            StAssert: begin
                if (cnt_q == AssertLast) begin
                    if (!req_fsm) begin
                        state_d = StRelPeriph;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelPeriph: begin
                if (req_fsm) begin
                    state_d   = StAssert;
                    cnt_d     = '0;
                    count_inc = 1'b1;
                end else if (cnt_q == GapLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (req_fsm) begin
                    state_d   = StAssert;
                    cnt_d     = '0;
                    count_inc = 1'b1;
                end
            end
            default: begin
                state_d = StAssert;
                cnt_d   = '0;
            end
        endcase
        count_d = (count_inc && (count_q != COUNT_SAT)) ? count_q + 1'b1 : count_q;
    end

    // State and registered outputs, decoded from the next state so they move
    // on the same edge as the FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StAssert;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            core_q   <= 1'b1;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= (state_d == StAssert);
            core_q   <= (state_d != StRun);
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign periph_reset_o = periph_q;
    assign core_reset_o   = core_q;
    assign reset_done_o   = done_q;
    assign reset_count_o  = count_q;

endmodule

// File: tb/tb_c_core_reset_sequencer.sv
// Directed bench for the core reset sequencer: power-on sequence, request
// pulses from RUN, re-assertion during the release gap, async reset and
// count saturation on a second, fast-configured instance.
module tb_c_core_reset_sequencer;

`ifdef C_CORE_RESET_SEQ_GLITCH_FILTER_EN
    localparam int ReqLat = 6;
`else
    localparam int ReqLat = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        periph, core, done;
    logic [15:0] count;

    logic        sat_req;
    logic        sat_periph, sat_core, sat_done;
    logic [15:0] sat_count;

    int n_vec = 0;
    int n_err = 0;

    c_core_reset_sequencer u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .periph_reset_o(periph),
        .core_reset_o  (core),
        .reset_done_o  (done),
        .reset_count_o (count)
    );

    c_core_reset_sequencer #(
        .MIN_ASSERT_CYCLES(3),
        .RELEASE_GAP      (1),
        .COUNT_SAT        (16'd20)
    ) u_dut_sat (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (sat_req),
        .periph_reset_o(sat_periph),
        .core_reset_o  (sat_core),
        .reset_done_o  (sat_done),
        .reset_count_o (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set before this are sampled at the posedge, outputs
    // are observed at the following negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // From index 0 (edge that entered ASSERT) walk the full release sequence.
    task automatic check_sequence(input string tag, input int exp_count);
        for (int i = 1; i <= 22; i++) begin
            step();
            check_val($sformatf("%s periph @%0d", tag, i), 32'(periph), 32'(i < 16));
            check_val($sformatf("%s core @%0d", tag, i), 32'(core), 32'(i < 20));
            check_val($sformatf("%s done @%0d", tag, i), 32'(done), 32'(i == 20));
        end
        check_val({tag, " count"}, 32'(count), 32'(exp_count));
    endtask

    // Hold req for len cycles, then step to the edge where ASSERT is entered.
    task automatic pulse_to_assert(input string tag, input int len, input int exp_count);
        req = 1'b1;
        for (int i = 0; i < len; i++) begin
            step();
            check_val({tag, " quiet periph"}, 32'(periph), 32'd0);
        end
        req = 1'b0;
        for (int i = 0; i < ReqLat - len; i++) begin
            step();
            check_val({tag, " quiet core"}, 32'(core), 32'd0);
        end
        step();
        check_val({tag, " entry periph"}, 32'(periph), 32'd1);
        check_val({tag, " entry core"}, 32'(core), 32'd1);
        check_val({tag, " entry count"}, 32'(count), 32'(exp_count));
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 1'b0;
        sat_req = 1'b0;
        #12;
        check_val("por periph", 32'(periph), 32'd1);
        check_val("por core", 32'(core), 32'd1);
        check_val("por done", 32'(done), 32'd0);
        check_val("por count", 32'(count), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        check_sequence("poweron", 0);

`ifdef C_CORE_RESET_SEQ_GLITCH_FILTER_EN
        // A single-cycle glitch must be swallowed by the filter.
        req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check_val("glitch periph", 32'(periph), 32'd0);
            check_val("glitch core", 32'(core), 32'd0);
        end
        check_val("glitch count", 32'(count), 32'd0);
        pulse_to_assert("long pulse", 6, 1);
        check_sequence("long pulse seq", 1);
`else
        pulse_to_assert("pulse1", 1, 1);
        check_sequence("pulse1 seq", 1);

        // Re-request two cycles into the release gap.
        pulse_to_assert("pulse2", 1, 2);
        for (int i = 1; i <= 15; i++) begin
            step();
            check_val("pre-gap periph", 32'(periph), 32'd1);
        end
        req = 1'b1;
        step();
        req = 1'b0;
        check_val("gap16 periph", 32'(periph), 32'd0);
        check_val("gap16 core", 32'(core), 32'd1);
        step();
        check_val("gap17 periph", 32'(periph), 32'd0);
        check_val("gap17 core", 32'(core), 32'd1);
        step();
        check_val("regap periph", 32'(periph), 32'd1);
        check_val("regap core", 32'(core), 32'd1);
        check_val("regap done", 32'(done), 32'd0);
        check_val("regap count", 32'(count), 32'd3);

        // Re-request landing on the gap-expiry edge.
        for (int i = 1; i <= 17; i++) begin
            step();
            check_val("co core", 32'(core), 32'd1);
            check_val("co done", 32'(done), 32'd0);
        end
        req = 1'b1;
        step();
        req = 1'b0;
        check_val("co18 periph", 32'(periph), 32'd0);
        step();
        check_val("co19 core", 32'(core), 32'd1);
        step();
        check_val("co20 periph", 32'(periph), 32'd1);
        check_val("co20 core", 32'(core), 32'd1);
        check_val("co20 done", 32'(done), 32'd0);
        check_val("co20 count", 32'(count), 32'd4);
        check_sequence("co seq", 4);
`endif

        // Asynchronous reset while running.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst periph", 32'(periph), 32'd1);
        check_val("arst core", 32'(core), 32'd1);
        check_val("arst done", 32'(done), 32'd0);
        check_val("arst count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_sequence("rearm", 0);

        // Saturation on the fast instance: one reset event per period.
        for (int i = 1; i <= 25; i++) begin
            sat_req = 1'b1;
            repeat (8) step();
            sat_req = 1'b0;
            repeat (12) step();
            check_val($sformatf("sat count %0d", i), 32'(sat_count),
                      32'((i < 20) ? i : 20));
            check_val("sat periph", 32'(sat_periph), 32'd0);
            check_val("sat core", 32'(sat_core), 32'd0);
            check_val("sat done", 32'(sat_done), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
